// File: rtl/RS5_pkg.sv
// Shared core types: atomic extension levels, atomic op encodings and the
// request/state enums used by the memory-side atomic responder.
package RS5_pkg;

  typedef enum logic [1:0] {
    AMO_OFF,
    AMO_ZALRSC,
    AMO_ZAAMO,
    AMO_A
  } atomic_e;

  typedef enum logic [9:0] {
    AMONOP  = 10'b0000000001,
    AMOSWAP = 10'b0000000010,
    AMOADD  = 10'b0000000100,
    AMOXOR  = 10'b0000001000,
    AMOAND  = 10'b0000010000,
    AMOOR   = 10'b0000100000,
    AMOMIN  = 10'b0001000000,
    AMOMAX  = 10'b0010000000,
    AMOMINU = 10'b0100000000,
    AMOMAXU = 10'b1000000000
  } iTypeAtomic_e;

  typedef enum logic [1:0] {
    AMO_REQ_RMW,
    AMO_REQ_LR,
    AMO_REQ_SC
  } amoReq_e;

  typedef enum logic [2:0] {
    AMO_IDLE,
    AMO_RD,
    AMO_CAP,
    AMO_WR,
    AMO_DONE
  } amo_states_e;

  // A read-modify-write needs exactly one real operation selected.
  function automatic logic rmw_op_valid(input logic [9:0] op);
    return $onehot(op) && (op != AMONOP);
  endfunction

endpackage

// File: rtl/amo_responder_alu.sv
// Combinational read-modify-write datapath: new memory word from the old
// word and rs2 for the selected atomic operation.
module amo_alu
  import RS5_pkg::*;
(
  input  logic [9:0]  op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] result_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    result_o = rs2_i;
    case (op_i)
      AMOSWAP: result_o = rs2_i;
      AMOADD:  result_o = old_i + rs2_i;
      AMOXOR:  result_o = old_i ^ rs2_i;
      AMOAND:  result_o = old_i & rs2_i;
      AMOOR:   result_o = old_i | rs2_i;
      AMOMIN:  result_o = ($signed(old_i) < $signed(rs2_i)) ? old_i : rs2_i;
      AMOMAX:  result_o = ($signed(old_i) > $signed(rs2_i)) ? old_i : rs2_i;
      AMOMINU: result_o = (old_i < rs2_i) ? old_i : rs2_i;
      AMOMAXU: result_o = (old_i > rs2_i) ? old_i : rs2_i;
      default: result_o = rs2_i;
    endcase
  end

endmodule

// File: rtl/amo_responder.sv
// Memory-side atomic responder: sequences LR/SC/AMO accesses to a 1-cycle
// single-ported RAM and owns the single LR reservation.
module amo_responder
  import RS5_pkg::*;
#(
  parameter atomic_e ATOMIC = AMO_A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  amoReq_e     req_kind_i,
  input  logic [9:0]  amo_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        error_o,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic LRSC_EN = (ATOMIC == AMO_ZALRSC) || (ATOMIC == AMO_A);
  localparam logic RMW_EN  = (ATOMIC == AMO_ZAAMO)  || (ATOMIC == AMO_A);

  amo_states_e state_q, state_d;
  amoReq_e     kind_q, kind_d;
  logic [9:0]  op_q, op_d;
  logic [29:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic        resv_valid_q, resv_valid_d;
  logic [29:0] resv_word_q, resv_word_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        mem_en_q, mem_en_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] alu_result;
  logic        kind_ok;
  logic        req_err;
  logic        unused_snoop_lsbs;

  assign unused_snoop_lsbs = ^snoop_addr_i[1:0];

  amo_alu u_alu (
    .op_i    (op_q),
    .old_i   (mem_rdata_i),
    .rs2_i   (wdata_q),
    .result_o(alu_result)
  );

  always_comb begin
    kind_ok = 1'b0;
    case (req_kind_i)
      AMO_REQ_RMW: kind_ok = RMW_EN && rmw_op_valid(amo_op_i);
      AMO_REQ_LR,
      AMO_REQ_SC:  kind_ok = LRSC_EN;
      default:     kind_ok = 1'b0;
    endcase
    req_err = (addr_i[1:0] != 2'b00) || !kind_ok;
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    op_d         = op_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    resv_valid_d = resv_valid_q;
    resv_word_d  = resv_word_q;
    done_d       = 1'b0;
    rdata_d      = '0;
    error_d      = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 4'h0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      AMO_IDLE: begin
        if (req_i) begin
          kind_d  = req_kind_i;
          op_d    = amo_op_i;
          word_d  = addr_i[31:2];
          wdata_d = wdata_i;
          if (req_err) begin
            state_d = AMO_DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (req_kind_i == AMO_REQ_SC) begin
            resv_valid_d = 1'b0;
            if (resv_valid_q && (resv_word_q == addr_i[31:2])) begin
              state_d     = AMO_WR;
              mem_en_d    = 1'b1;
              mem_we_d    = 4'hF;
              mem_addr_d  = {addr_i[31:2], 2'b00};
              mem_wdata_d = wdata_i;
            end else begin
              state_d = AMO_DONE;
              done_d  = 1'b1;
              rdata_d = 32'd1;
            end
          end else begin
            state_d    = AMO_RD;
            mem_en_d   = 1'b1;
            mem_addr_d = {addr_i[31:2], 2'b00};
          end
        end
      end
      AMO_RD: state_d = AMO_CAP;
      AMO_CAP: begin
        old_d = mem_rdata_i;
        if (kind_q == AMO_REQ_LR) begin
          state_d      = AMO_DONE;
          done_d       = 1'b1;
          rdata_d      = mem_rdata_i;
          resv_valid_d = 1'b1;
          resv_word_d  = word_q;
        end else begin
          state_d     = AMO_WR;
          mem_en_d    = 1'b1;
          mem_we_d    = 4'hF;
          mem_addr_d  = {word_q, 2'b00};
          mem_wdata_d = alu_result;
        end
      end
      AMO_WR: begin
        state_d = AMO_DONE;
        done_d  = 1'b1;
        rdata_d = (kind_q == AMO_REQ_SC) ? '0 : old_q;
        if ((kind_q == AMO_REQ_RMW) && (resv_word_q == word_q)) resv_valid_d = 1'b0;
      end
      AMO_DONE: state_d = AMO_IDLE;
      default:  state_d = AMO_IDLE;
    endcase

    // Compared against the post-update address so a same-cycle snoop beats an LR set.
    if (snoop_we_i && (snoop_addr_i[31:2] == resv_word_d)) resv_valid_d = 1'b0;

    busy_d = (state_d != AMO_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q      <= AMO_IDLE;
      kind_q       <= AMO_REQ_RMW;
      op_q         <= '0;
      word_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      resv_valid_q <= 1'b0;
      resv_word_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      op_q         <= op_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      resv_valid_q <= resv_valid_d;
      resv_word_q  <= resv_word_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign error_o     = error_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_amo_responder.sv
// Bench for amo_responder: a bench-owned RAM, a transaction-level model of
// memory and reservation, and a per-cycle compare process.
module tb_amo_responder;
  import RS5_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i;
  amoReq_e     req_kind_i;
  logic [9:0]  amo_op_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, error_o;
  logic [31:0] rdata_o;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;

  amo_responder #(.ATOMIC(AMO_A)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_kind_i(req_kind_i),
    .amo_op_i(amo_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .error_o(error_o),
    .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Bench-owned RAM: 1-cycle read latency, byte-enabled writes.
  logic [31:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o == 4'h0) mem_rdata_i <= ram[mem_addr_o[12:2]];
      else for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_addr_o[12:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] model_mem [0:2047];
  logic        model_rv;
  logic [29:0] model_rw;
  logic        snoop_rand;

  // Per-cycle expectations, consumed by the compare process.
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_done, exp_err, exp_mem_en;
  logic [3:0]  exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_o", busy_o, exp_busy);
      check("done_o", done_o, exp_done);
      check("mem_en_o", mem_en_o, exp_mem_en);
      if (exp_mem_en) begin
        check("mem_we_o", mem_we_o, exp_we);
        check("mem_addr_o", mem_addr_o, exp_addr);
        if (exp_we != 4'h0) check("mem_wdata_o", mem_wdata_o, exp_wdata);
      end
      if (exp_done) begin
        check("rdata_o", rdata_o, exp_rdata);
        check("error_o", error_o, exp_err);
      end
    end
  end

  function automatic logic [31:0] amo_f(input logic [9:0] op, input logic [31:0] o, input logic [31:0] r);
    case (op)
      AMOSWAP: return r;
      AMOADD:  return o + r;
      AMOXOR:  return o ^ r;
      AMOAND:  return o & r;
      AMOOR:   return o | r;
      AMOMIN:  return ($signed(o) <= $signed(r)) ? o : r;
      AMOMAX:  return ($signed(o) >= $signed(r)) ? o : r;
      AMOMINU: return (o <= r) ? o : r;
      AMOMAXU: return (o >= r) ? o : r;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_mem_en = 1'b0;
    exp_we = 4'h0; exp_rdata = '0; exp_addr = '0; exp_wdata = '0;
  endtask

  task automatic rand_snoop();
    if (snoop_rand && ($urandom_range(0, 7) == 0)) begin
      snoop_we_i   = 1'b1;
      snoop_addr_i = 32'h600 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
    end else begin
      snoop_we_i = 1'b0;
    end
  endtask

  task automatic apply_snoop();
    if (snoop_we_i && (snoop_addr_i[31:2] == model_rw)) model_rv = 1'b0;
  endtask

  task automatic idle_cycle();
    set_idle_exp();
    rand_snoop();
    @(posedge clk);
    apply_snoop();
    #1;
    snoop_we_i = 1'b0;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    ram[a[12:2]] = v;
    model_mem[a[12:2]] = v;
  endtask

  // One request; rst_cyc > 0 asserts reset during that cycle after acceptance.
  task automatic do_op(input amoReq_e k, input logic [9:0] op, input logic [31:0] a,
                       input logic [31:0] w, input int rst_cyc,
                       output logic [31:0] got_rdata, output logic got_err,
                       output logic [31:0] got_wdata);
    logic [29:0] wd;
    logic [10:0] idx;
    logic        err, sc_ok;
    logic [31:0] old, nv;
    int          lat;
    wd    = a[31:2];
    idx   = a[12:2];
    err   = (a[1:0] != 2'b00) ||
            ((k == AMO_REQ_RMW) && !(($countones(op) == 1) && (op != AMONOP)));
    old   = model_mem[idx];
    nv    = amo_f(op, old, w);
    sc_ok = model_rv && (model_rw == wd);
    if (err) lat = 1;
    else if (k == AMO_REQ_RMW) lat = 4;
    else if (k == AMO_REQ_LR) lat = 3;
    else lat = sc_ok ? 2 : 1;
    got_rdata = 'x; got_err = 1'bx; got_wdata = 'x;

    req_i = 1'b1; req_kind_i = k; amo_op_i = op; addr_i = a; wdata_i = w;
    set_idle_exp();
    rand_snoop();
    @(posedge clk);
    if (!err && (k == AMO_REQ_SC)) model_rv = 1'b0;
    apply_snoop();
    #1;
    for (int c = 1; c <= lat; c++) begin
      // Requests while busy must be ignored.
      req_i      = 1'($urandom_range(0, 1));
      req_kind_i = amoReq_e'($urandom_range(0, 2));
      amo_op_i   = 10'($urandom);
      addr_i     = $urandom;
      wdata_i    = $urandom;
      set_idle_exp();
      exp_busy = 1'b1;
      exp_done = (c == lat);
      if (exp_done) begin
        exp_err   = err;
        exp_rdata = err ? 32'h0 : (k == AMO_REQ_SC) ? (sc_ok ? 32'h0 : 32'h1) : old;
      end
      if (!err) begin
        exp_addr = {wd, 2'b00};
        if ((c == 1) && (k != AMO_REQ_SC)) exp_mem_en = 1'b1;
        if ((c == 1) && (k == AMO_REQ_SC) && sc_ok) begin
          exp_mem_en = 1'b1; exp_we = 4'hF; exp_wdata = w;
        end
        if ((c == 3) && (k == AMO_REQ_RMW)) begin
          exp_mem_en = 1'b1; exp_we = 4'hF; exp_wdata = nv;
        end
      end
      reset = (c == rst_cyc);
      rand_snoop();
      @(negedge clk);
      if (exp_done) begin got_rdata = rdata_o; got_err = error_o; end
      if (exp_mem_en && (exp_we != 4'h0)) got_wdata = mem_wdata_o;
      @(posedge clk);
      if (reset) begin
        model_rv = 1'b0;
        #1;
        reset = 1'b0; req_i = 1'b0; snoop_we_i = 1'b0;
        set_idle_exp();
        return;
      end
      if (!err && (k == AMO_REQ_LR) && (c == 2)) begin model_rv = 1'b1; model_rw = wd; end
      if (!err && (k == AMO_REQ_RMW) && (c == 3)) begin
        model_mem[idx] = nv;
        if (model_rw == wd) model_rv = 1'b0;
      end
      if (!err && (k == AMO_REQ_SC) && sc_ok && (c == 1)) model_mem[idx] = w;
      apply_snoop();
      #1;
    end
    req_i = 1'b0; snoop_we_i = 1'b0;
    set_idle_exp();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    check({tag, "_error"}, error_o, 1'b0);
    check({tag, "_mem_en"}, mem_en_o, 1'b0);
    check({tag, "_mem_we"}, mem_we_o, 4'h0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
  endtask

  initial begin
    logic [31:0] r, wv, a, w;
    logic        e;
    logic [9:0]  op;
    amoReq_e     k;
    int          bad;

    reset = 1'b1; req_i = 1'b0; req_kind_i = AMO_REQ_RMW; amo_op_i = '0;
    addr_i = '0; wdata_i = '0; snoop_we_i = 1'b0; snoop_addr_i = '0;
    snoop_rand = 1'b0; model_rv = 1'b0; model_rw = '0;
    set_idle_exp();
    for (int i = 0; i < 2048; i++) begin
      w = $urandom;
      ram[i] = w;
      model_mem[i] = w;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    idle_cycle();

    // AMOADD: old 5, rs2 3.
    set_word(32'h100, 32'd5);
    do_op(AMO_REQ_RMW, AMOADD, 32'h100, 32'd3, 0, r, e, wv);
    check("amoadd_rdata", r, 32'd5);
    check("amoadd_wdata", wv, 32'd8);
    idle_cycle();
    check("amoadd_ram", ram[32'h100 >> 2], 32'd8);

    // LR then matching SC.
    set_word(32'h200, 32'h11);
    do_op(AMO_REQ_LR, AMONOP, 32'h200, 32'h0, 0, r, e, wv);
    check("lr_rdata", r, 32'h11);
    do_op(AMO_REQ_SC, AMONOP, 32'h200, 32'h22, 0, r, e, wv);
    check("sc_ok_rdata", r, 32'h0);
    idle_cycle();
    check("sc_ok_ram", ram[32'h200 >> 2], 32'h22);

    // Snoop to the reserved word kills the reservation.
    do_op(AMO_REQ_LR, AMONOP, 32'h200, 32'h0, 0, r, e, wv);
    set_idle_exp();
    snoop_we_i = 1'b1; snoop_addr_i = 32'h203;
    @(posedge clk);
    apply_snoop();
    #1;
    snoop_we_i = 1'b0;
    do_op(AMO_REQ_SC, AMONOP, 32'h200, 32'h33, 0, r, e, wv);
    check("sc_snooped_rdata", r, 32'h1);
    do_op(AMO_REQ_SC, AMONOP, 32'h200, 32'h44, 0, r, e, wv);
    check("sc_second_rdata", r, 32'h1);

    // Signed vs unsigned minimum.
    set_word(32'h300, 32'hFFFF_FFFF);
    do_op(AMO_REQ_RMW, AMOMIN, 32'h300, 32'h1, 0, r, e, wv);
    check("amomin_rdata", r, 32'hFFFF_FFFF);
    check("amomin_wdata", wv, 32'hFFFF_FFFF);
    set_word(32'h300, 32'hFFFF_FFFF);
    do_op(AMO_REQ_RMW, AMOMINU, 32'h300, 32'h1, 0, r, e, wv);
    check("amominu_rdata", r, 32'hFFFF_FFFF);
    check("amominu_wdata", wv, 32'h0000_0001);

    // Errors: misaligned, and a two-hot op.
    do_op(AMO_REQ_RMW, AMOSWAP, 32'h1002, 32'h5, 0, r, e, wv);
    check("misaligned_err", e, 1'b1);
    check("misaligned_rdata", r, 32'h0);
    do_op(AMO_REQ_RMW, 10'b0000000110, 32'h100, 32'h5, 0, r, e, wv);
    check("badop_err", e, 1'b1);

    // Reset during CAP abandons the AMOOR and drops the reservation.
    set_word(32'h500, 32'h0F0F_0000);
    do_op(AMO_REQ_LR, AMONOP, 32'h400, 32'h0, 0, r, e, wv);
    do_op(AMO_REQ_RMW, AMOOR, 32'h500, 32'h0000_00FF, 2, r, e, wv);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    repeat (3) idle_cycle();
    check("midreset_no_wr", ram[32'h500 >> 2], 32'h0F0F_0000);
    do_op(AMO_REQ_SC, AMONOP, 32'h400, 32'h9, 0, r, e, wv);
    check("midreset_sc_rdata", r, 32'h1);

    // Randomized traffic over a small set of words with random snoops.
    snoop_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      k  = amoReq_e'($urandom_range(0, 2));
      a  = 32'h600 + ($urandom_range(0, 5) << 2);
      if ($urandom_range(0, 15) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 11) == 0) op = 10'($urandom);
      else op = 10'(1 << $urandom_range(1, 9));
      case ($urandom_range(0, 3))
        0:       w = 32'h8000_0000;
        1:       w = 32'hFFFF_FFFF;
        default: w = $urandom;
      endcase
      do_op(k, op, a, w, 0, r, e, wv);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    snoop_rand = 1'b0;
    idle_cycle();

    bad = 0;
    for (int i = 0; i < 2048; i++) if (ram[i] !== model_mem[i]) bad++;
    check("ram_vs_model", bad, 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
